// File: rtl/cfg_regs_pkg.sv
// -----------------------------------------------------------------------------
// cfg_regs_pkg
// Shared definitions for the configuration register file and its consumers:
//   - default geometry of the register store
//   - register index map of the exported configuration words
//   - reset defaults for the UART configuration and clock-divider words
//   - request classification used by the register file decode
// -----------------------------------------------------------------------------
package cfg_regs_pkg;

   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 16;
   localparam int NUM_EXPORT_DEF = 4;

   // Exported word indices
   localparam int ALU_OP_A  = 0;
   localparam int ALU_OP_B  = 1;
   localparam int UART_CFG  = 2;
   localparam int DIV_RATIO = 3;

   localparam logic [DATA_WIDTH_DEF-1:0] ALU_OP_RST    = 8'h00;
   localparam logic [DATA_WIDTH_DEF-1:0] UART_CFG_RST  = 8'h81;
   localparam logic [DATA_WIDTH_DEF-1:0] DIV_RATIO_RST = 8'h20;

   // Kind of request presented by the controller in one cycle
   typedef enum logic [1:0] {
      REQ_IDLE     = 2'd0,
      REQ_WRITE    = 2'd1,
      REQ_READ     = 2'd2,
      REQ_CONFLICT = 2'd3
   } req_kind_e;

   function automatic req_kind_e classify_req(input logic wr_en, input logic rd_en);
      req_kind_e kind;
      case ({wr_en, rd_en})
         2'b10:   kind = REQ_WRITE;
         2'b01:   kind = REQ_READ;
         2'b11:   kind = REQ_CONFLICT;
         default: kind = REQ_IDLE;
      endcase
      return kind;
   endfunction

   // Flattened reset image for the default geometry; unlisted words reset to 0
   function automatic logic [DEPTH_DEF*DATA_WIDTH_DEF-1:0] build_rst_values();
      logic [DEPTH_DEF*DATA_WIDTH_DEF-1:0] v;
      v = '0;
      v[ALU_OP_A*DATA_WIDTH_DEF  +: DATA_WIDTH_DEF] = ALU_OP_RST;
      v[ALU_OP_B*DATA_WIDTH_DEF  +: DATA_WIDTH_DEF] = ALU_OP_RST;
      v[UART_CFG*DATA_WIDTH_DEF  +: DATA_WIDTH_DEF] = UART_CFG_RST;
      v[DIV_RATIO*DATA_WIDTH_DEF +: DATA_WIDTH_DEF] = DIV_RATIO_RST;
      return v;
   endfunction

   localparam logic [DEPTH_DEF*DATA_WIDTH_DEF-1:0] RST_VALUES_DEF = build_rst_values();

endpackage

// File: rtl/config_reg_file.sv
// -----------------------------------------------------------------------------
// config_reg_file
// Single-master configuration register store with per-word reset values,
// per-word write protection, write acknowledge and error reporting. The low
// NUM_EXPORT words are driven straight from the storage flops onto Export.
//
// Ports:
//   CLK           system clock (rising edge)
//   RST           asynchronous active-low reset
//   Address       word address
//   WrEn / RdEn   one-cycle write / read requests
//   WrData        write data
//   RdData        registered read data (holds between reads)
//   RdData_Valid  one-cycle pulse, RdData updated by a read
//   WrAck         one-cycle pulse, write accepted
//   Err           one-cycle pulse, request rejected
//   ErrSticky     latched error flag, cleared by ErrClr (set has priority)
//   ErrClr        clears ErrSticky
//   Export        words 0..NUM_EXPORT-1, word i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module config_reg_file
   import cfg_regs_pkg::*;
#(
   parameter int                          ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int                          DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int                          DEPTH      = DEPTH_DEF,
   parameter int                          NUM_EXPORT = NUM_EXPORT_DEF,
   parameter logic [DEPTH*DATA_WIDTH-1:0] RST_VALUES = RST_VALUES_DEF,
   parameter logic [DEPTH-1:0]            RO_MASK    = '0
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [ADDR_WIDTH-1:0]            Address,
   input  logic                             WrEn,
   input  logic                             RdEn,
   input  logic [DATA_WIDTH-1:0]            WrData,
   output logic [DATA_WIDTH-1:0]            RdData,
   output logic                             RdData_Valid,
   output logic                             WrAck,
   output logic                             Err,
   output logic                             ErrSticky,
   input  logic                             ErrClr,
   output logic [NUM_EXPORT*DATA_WIDTH-1:0] Export
);

   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   req_kind_e             req_kind;
   logic                  addr_in_range;
   logic                  addr_ro;
   logic                  wr_accept;
   logic                  rd_take;
   logic                  err_next;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] rd_data_p1;
   logic                  vld_p1;
   logic                  wr_ack_p1;
   logic                  err_p1;
   logic                  err_sticky_p1;

   // ---- stage p0: request decode --------------------------------------------
   // The word select compares against every implemented index explicitly, so an
   // out-of-range address matches nothing and can never alias onto a real word.
   always_comb begin
      req_kind      = classify_req(WrEn, RdEn);
      addr_in_range = ({1'b0, Address} < DEPTH_LIM);
      addr_ro       = 1'b0;
      rd_word       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (Address == ADDR_WIDTH'(i)) begin
            addr_ro = RO_MASK[i];
            rd_word = mem[i];
         end
      end
   end

   always_comb begin
      wr_accept = 1'b0;
      rd_take   = 1'b0;
      err_next  = 1'b0;
      case (req_kind)
         REQ_WRITE: begin
            wr_accept = addr_in_range && !addr_ro;
            err_next  = !(addr_in_range && !addr_ro);
         end
         REQ_READ: begin
            rd_take  = 1'b1;
            err_next = !addr_in_range;
         end
         REQ_CONFLICT: begin
            err_next = 1'b1;
         end
         default: begin
            err_next = 1'b0;
         end
      endcase
   end

   // ---- stage p1: storage and response registers -----------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RST_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end else if (wr_accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (Address == ADDR_WIDTH'(i)) begin
               mem[i] <= WrData;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_data_p1    <= '0;
         vld_p1        <= 1'b0;
         wr_ack_p1     <= 1'b0;
         err_p1        <= 1'b0;
         err_sticky_p1 <= 1'b0;
      end else begin
         // Out-of-range reads return zero because rd_word defaults to zero
         if (rd_take) begin
            rd_data_p1 <= rd_word;
         end
         vld_p1    <= rd_take;
         wr_ack_p1 <= wr_accept;
         err_p1    <= err_next;
         // A new error outranks a simultaneous clear
         if (err_next) begin
            err_sticky_p1 <= 1'b1;
         end else if (ErrClr) begin
            err_sticky_p1 <= 1'b0;
         end
      end
   end

   assign RdData       = rd_data_p1;
   assign RdData_Valid = vld_p1;
   assign WrAck        = wr_ack_p1;
   assign Err          = err_p1;
   assign ErrSticky    = err_sticky_p1;

   // Export is wired straight from storage: a write is visible the cycle after
   // its edge, together with WrAck.
   for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
      assign Export[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
   end

endmodule

// File: tb/tb_config_reg_file.sv
// -----------------------------------------------------------------------------
// tb_config_reg_file
// Three register files share one request bus:
//   0: default geometry, no protection
//   1: default geometry, word 3 read-only
//   2: DEPTH = 12
// A behavioural model of the register store tracks each instance.
// -----------------------------------------------------------------------------
module tb_config_reg_file;
   import cfg_regs_pkg::*;

   localparam int NI = 3;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] Address;
   logic       WrEn;
   logic       RdEn;
   logic       ErrClr;
   logic [7:0] WrData;

   logic [7:0]  rd_data    [NI];
   logic        rd_vld     [NI];
   logic        wr_ack     [NI];
   logic        err        [NI];
   logic        err_sticky [NI];
   logic [31:0] export_bus [NI];

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   config_reg_file dut_def (
      .CLK(CLK), .RST(RST), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
      .WrData(WrData), .RdData(rd_data[0]), .RdData_Valid(rd_vld[0]),
      .WrAck(wr_ack[0]), .Err(err[0]), .ErrSticky(err_sticky[0]),
      .ErrClr(ErrClr), .Export(export_bus[0])
   );

   config_reg_file #(.RO_MASK(16'h0008)) dut_ro (
      .CLK(CLK), .RST(RST), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
      .WrData(WrData), .RdData(rd_data[1]), .RdData_Valid(rd_vld[1]),
      .WrAck(wr_ack[1]), .Err(err[1]), .ErrSticky(err_sticky[1]),
      .ErrClr(ErrClr), .Export(export_bus[1])
   );

   config_reg_file #(
      .DEPTH(12),
      .RST_VALUES(96'h0000000000000000_2081_0000)
   ) dut_d12 (
      .CLK(CLK), .RST(RST), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
      .WrData(WrData), .RdData(rd_data[2]), .RdData_Valid(rd_vld[2]),
      .WrAck(wr_ack[2]), .Err(err[2]), .ErrSticky(err_sticky[2]),
      .ErrClr(ErrClr), .Export(export_bus[2])
   );

   // ---------------- reference model ----------------
   int          m_depth [NI] = '{16, 16, 12};
   logic [15:0] m_ro    [NI] = '{16'h0000, 16'h0008, 16'h0000};
   logic [7:0]  m_mem   [NI][16];
   logic [7:0]  m_rd    [NI];
   logic        m_vld   [NI];
   logic        m_ack   [NI];
   logic        m_err   [NI];
   logic        m_sticky[NI];

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         for (int w = 0; w < 16; w++) begin
            m_mem[k][w] = (w == 2) ? 8'h81 : (w == 3) ? 8'h20 : 8'h00;
         end
         m_rd[k] = 8'h00; m_vld[k] = 1'b0; m_ack[k] = 1'b0;
         m_err[k] = 1'b0; m_sticky[k] = 1'b0;
      end
   endtask

   task automatic model_step(input logic wr, input logic rd, input logic [3:0] addr,
                             input logic [7:0] data, input logic clr);
      int a;
      bit inr;
      a = int'(addr);
      for (int k = 0; k < NI; k++) begin
         inr = (a < m_depth[k]);
         m_vld[k] = 1'b0; m_ack[k] = 1'b0; m_err[k] = 1'b0;
         if (wr && rd) begin
            m_err[k] = 1'b1;
         end else if (wr) begin
            if (inr && !m_ro[k][a]) begin
               m_mem[k][a] = data;
               m_ack[k] = 1'b1;
            end else begin
               m_err[k] = 1'b1;
            end
         end else if (rd) begin
            m_vld[k] = 1'b1;
            m_rd[k]  = inr ? m_mem[k][a] : 8'h00;
            m_err[k] = !inr;
         end
         if (m_err[k]) m_sticky[k] = 1'b1;
         else if (clr) m_sticky[k] = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_export(input int k);
      return {m_mem[k][3], m_mem[k][2], m_mem[k][1], m_mem[k][0]};
   endfunction

   // One request cycle: drive, clock, advance the model, settle
   task automatic do_cycle(input logic wr, input logic rd, input logic [3:0] addr,
                           input logic [7:0] data, input logic clr);
      WrEn = wr; RdEn = rd; Address = addr; WrData = data; ErrClr = clr;
      @(posedge CLK);
      model_step(wr, rd, addr, data, clr);
      #1;
      WrEn = 1'b0; RdEn = 1'b0; ErrClr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      WrEn = 1'b0; RdEn = 1'b0; ErrClr = 1'b0; Address = '0; WrData = '0;
      RST = 1'b1;
      #1 RST = 1'b0;
      #2;
      model_reset();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (export_bus[k] !== 32'h2081_0000) begin
            errors++; $display("FAIL reset_export[%0d] got %h want %h", k, export_bus[k], 32'h2081_0000);
         end
         checks++;
         if ({rd_data[k], rd_vld[k], wr_ack[k], err[k], err_sticky[k]} !== 12'h000) begin
            errors++; $display("FAIL reset_outputs[%0d] got rd=%h v=%b a=%b e=%b s=%b want all 0",
                               k, rd_data[k], rd_vld[k], wr_ack[k], err[k], err_sticky[k]);
         end
      end
      @(negedge CLK) RST = 1'b1;
   endtask

   task automatic test_write_read();
      do_cycle(1'b1, 1'b0, 4'd1, 8'hA5, 1'b0);
      checks++;
      if (wr_ack[0] !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", wr_ack[0]); end
      checks++;
      if (export_bus[0][15:8] !== 8'hA5) begin
         errors++; $display("FAIL wr_export got %h want a5", export_bus[0][15:8]);
      end
      checks++;
      if (err[0] !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", err[0]); end
      do_cycle(1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
      checks++;
      if (rd_data[0] !== 8'hA5 || rd_vld[0] !== 1'b1) begin
         errors++; $display("FAIL rd_after_wr got %h/%b want a5/1", rd_data[0], rd_vld[0]);
      end
      checks++;
      if (wr_ack[0] !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", wr_ack[0]); end
   endtask

   task automatic test_ro_protect();
      do_cycle(1'b1, 1'b0, 4'd3, 8'h04, 1'b0);
      checks++;
      if (err[1] !== 1'b1 || err_sticky[1] !== 1'b1 || wr_ack[1] !== 1'b0) begin
         errors++; $display("FAIL ro_err got e=%b s=%b a=%b want 1 1 0", err[1], err_sticky[1], wr_ack[1]);
      end
      checks++;
      if (export_bus[1][31:24] !== 8'h20) begin
         errors++; $display("FAIL ro_word3 got %h want 20", export_bus[1][31:24]);
      end
      checks++;
      if (export_bus[0][31:24] !== 8'h04) begin
         errors++; $display("FAIL rw_word3 got %h want 04", export_bus[0][31:24]);
      end
      do_cycle(1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
      checks++;
      if (rd_data[1] !== 8'h20 || err[1] !== 1'b0) begin
         errors++; $display("FAIL ro_readable got %h/%b want 20/0", rd_data[1], err[1]);
      end
      do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      checks++;
      if (err_sticky[1] !== 1'b0 || err[1] !== 1'b0) begin
         errors++; $display("FAIL ro_clear got s=%b e=%b want 0 0", err_sticky[1], err[1]);
      end
      do_cycle(1'b1, 1'b0, 4'd3, 8'h04, 1'b1);
      checks++;
      if (err_sticky[1] !== 1'b1) begin
         errors++; $display("FAIL set_wins got %b want 1", err_sticky[1]);
      end
      checks++;
      if (err_sticky[0] !== 1'b0) begin
         errors++; $display("FAIL clr_no_err got %b want 0", err_sticky[0]);
      end
      do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
   endtask

   task automatic test_out_of_range();
      do_cycle(1'b0, 1'b1, 4'd2, 8'h00, 1'b0);
      checks++;
      if (rd_data[2] !== 8'h81) begin errors++; $display("FAIL d12_rd2 got %h want 81", rd_data[2]); end
      do_cycle(1'b0, 1'b1, 4'd13, 8'h00, 1'b0);
      checks++;
      if (rd_data[2] !== 8'h00 || rd_vld[2] !== 1'b1 || err[2] !== 1'b1) begin
         errors++; $display("FAIL oor_read got %h/%b/%b want 00/1/1", rd_data[2], rd_vld[2], err[2]);
      end
      checks++;
      if (err[0] !== 1'b0 || rd_vld[0] !== 1'b1) begin
         errors++; $display("FAIL inrange13 got e=%b v=%b want 0 1", err[0], rd_vld[0]);
      end
      do_cycle(1'b1, 1'b0, 4'd13, 8'h5A, 1'b0);
      checks++;
      if (err[2] !== 1'b1 || wr_ack[2] !== 1'b0) begin
         errors++; $display("FAIL oor_write got e=%b a=%b want 1 0", err[2], wr_ack[2]);
      end
      for (int w = 0; w < 12; w++) begin
         do_cycle(1'b0, 1'b1, 4'(w), 8'h00, 1'b0);
         checks++;
         if (rd_data[2] !== m_mem[2][w] || rd_data[2] === 8'h5A) begin
            errors++; $display("FAIL oor_alias word%0d got %h want %h", w, rd_data[2], m_mem[2][w]);
         end
      end
      do_cycle(1'b0, 1'b1, 4'd13, 8'h00, 1'b0);
      checks++;
      if (rd_data[0] !== 8'h5A) begin errors++; $display("FAIL word13 got %h want 5a", rd_data[0]); end
   endtask

   task automatic test_conflict();
      do_cycle(1'b1, 1'b1, 4'd0, 8'hFF, 1'b0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (err[k] !== 1'b1 || rd_vld[k] !== 1'b0 || wr_ack[k] !== 1'b0) begin
            errors++; $display("FAIL conflict_pulses[%0d] got e=%b v=%b a=%b want 1 0 0",
                               k, err[k], rd_vld[k], wr_ack[k]);
         end
         checks++;
         if (export_bus[k][7:0] !== 8'h00 || rd_data[k] !== m_rd[k]) begin
            errors++; $display("FAIL conflict_state[%0d] got w0=%h rd=%h want 00/%h",
                               k, export_bus[k][7:0], rd_data[k], m_rd[k]);
         end
      end
      do_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 4; a++) begin
         do_cycle(1'b0, 1'b1, 4'(a), 8'h00, 1'b0);
         checks++;
         if (rd_vld[0] !== 1'b1 || rd_data[0] !== m_mem[0][a]) begin
            errors++; $display("FAIL b2b_read%0d got %h/%b want %h/1", a, rd_data[0], rd_vld[0], m_mem[0][a]);
         end
      end
      // write then immediately read the same word
      do_cycle(1'b1, 1'b0, 4'd0, 8'h3C, 1'b0);
      do_cycle(1'b0, 1'b1, 4'd0, 8'h00, 1'b0);
      checks++;
      if (rd_data[0] !== 8'h3C) begin errors++; $display("FAIL wr_then_rd got %h want 3c", rd_data[0]); end
      // reset in the middle of a read stream
      do_cycle(1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
      WrEn = 1'b0; RdEn = 1'b1; Address = 4'd2;
      RST = 1'b0;
      #2;
      model_reset();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (export_bus[k] !== 32'h2081_0000 ||
             {rd_data[k], rd_vld[k], wr_ack[k], err[k], err_sticky[k]} !== 12'h000) begin
            errors++; $display("FAIL midreset[%0d] got exp=%h rd=%h v=%b a=%b e=%b s=%b want 20810000 and 0s",
                               k, export_bus[k], rd_data[k], rd_vld[k], wr_ack[k], err[k], err_sticky[k]);
         end
      end
      RdEn = 1'b0;
      @(negedge CLK) RST = 1'b1;
      do_cycle(1'b0, 1'b1, 4'd0, 8'h00, 1'b0);
      checks++;
      if (rd_data[0] !== 8'h00 || rd_vld[0] !== 1'b1) begin
         errors++; $display("FAIL post_reset_rd got %h/%b want 00/1", rd_data[0], rd_vld[0]);
      end
   endtask

   task automatic test_random();
      logic       wr, rd, clr;
      logic [3:0] addr;
      logic [7:0] data;
      int         sel;
      for (int n = 0; n < 400; n++) begin
         sel  = int'($urandom_range(0, 19));
         wr   = (sel < 8) || (sel == 19);
         rd   = (sel >= 8 && sel < 16) || (sel == 19);
         addr = 4'($urandom_range(0, 15));
         data = 8'($urandom);
         clr  = ($urandom_range(0, 4) == 0);
         do_cycle(wr, rd, addr, data, clr);
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (rd_data[k] !== m_rd[k] || rd_vld[k] !== m_vld[k]) begin
               errors++; $display("FAIL rnd_read[%0d] n=%0d got %h/%b want %h/%b",
                                  k, n, rd_data[k], rd_vld[k], m_rd[k], m_vld[k]);
            end
            checks++;
            if (wr_ack[k] !== m_ack[k] || err[k] !== m_err[k] || err_sticky[k] !== m_sticky[k]) begin
               errors++; $display("FAIL rnd_flags[%0d] n=%0d got a=%b e=%b s=%b want a=%b e=%b s=%b",
                                  k, n, wr_ack[k], err[k], err_sticky[k], m_ack[k], m_err[k], m_sticky[k]);
            end
            checks++;
            if (export_bus[k] !== exp_export(k)) begin
               errors++; $display("FAIL rnd_export[%0d] n=%0d got %h want %h", k, n, export_bus[k], exp_export(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_ro_protect();
      test_out_of_range();
      test_conflict();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got no completion want finish within 500000");
      $fatal(1);
   end

endmodule

// File: doc/config_reg_file.md
Name: config_reg_file

Overview:
Parametrised configuration register file: the next generation of the system's single-port register store.
- Holds DEPTH words of DATA_WIDTH bits.
- Exports the low NUM_EXPORT words as live configuration buses for ALU, UART and clock divider.
- Adds per-word reset values, per-word write protection, accepted-write acknowledge and error reporting.
- Sits between the system controller (sole read/write master) and the configurable datapath blocks in the reference clock domain.

Parameters:
ADDR_WIDTH, 4, address bus width
DATA_WIDTH, 8, word width
DEPTH, 16, number of implemented words; must satisfy NUM_EXPORT <= DEPTH <= 2**ADDR_WIDTH
NUM_EXPORT, 4, words 0..NUM_EXPORT-1 driven onto Export bus
RST_VALUES, {DEPTH*DATA_WIDTH{0}} with word2=8'h81 and word3=8'h20, flattened per-word reset values; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
RO_MASK, {DEPTH{1'b0}}, bit i = 1 makes word i read-only

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
Address  input  ADDR_WIDTH  word address
WrEn  input  1  write request, one cycle per transaction
RdEn  input  1  read request, one cycle per transaction
WrData  input  DATA_WIDTH  write data
RdData  output  DATA_WIDTH  registered read data
RdData_Valid  output  1  one-cycle pulse, RdData valid
WrAck  output  1  one-cycle pulse, write accepted
Err  output  1  one-cycle pulse, request rejected
ErrSticky  output  1  latched error flag
ErrClr  input  1  clears ErrSticky
Export  output  NUM_EXPORT*DATA_WIDTH  live contents of words 0..NUM_EXPORT-1; word i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (RST low, asynchronous): every word <- RST_VALUES slice. RdData=0, RdData_Valid=0, WrAck=0, Err=0, ErrSticky=0. Export therefore equals the reset values immediately.
- All state is updated on the CLK rising edge only. Each request is evaluated in the cycle it is presented; there is no queueing.
- Accepted write (WrEn=1, RdEn=0, Address<DEPTH, RO_MASK[Address]=0):
  - Word is updated at the edge.
  - WrAck=1 for the next cycle.
  - Export reflects the new value in that same cycle (zero added lag; export is wired straight from the storage flops).
- Rejected write (Address>=DEPTH or RO_MASK bit set): storage unchanged, WrAck=0, Err=1 for one cycle.
- Read (RdEn=1, WrEn=0):
  - 1-cycle latency: RdData <= word[Address] and RdData_Valid=1 in the next cycle.
  - Address>=DEPTH: RdData <= 0, RdData_Valid=1, Err=1.
  - Read-only words are readable.
- WrEn=1 and RdEn=1 together: no storage change, RdData unchanged, RdData_Valid=0, WrAck=0, Err=1.
- Idle (neither request): RdData holds its last value. RdData_Valid, WrAck and Err are 0.
- Back-to-back transactions are allowed every cycle. A read of word A in the cycle after a write to A returns the new data.
- ErrSticky:
  - Set on any cycle where Err is asserted next.
  - ErrClr=1 clears it.
  - Simultaneous set and clear: set wins.
- Out-of-range addresses never alias onto implemented words.

Decomposition:
- Shared package cfg_regs_pkg holds:
  - default widths;
  - register index constants: ALU_OP_A=0, ALU_OP_B=1, UART_CFG=2, DIV_RATIO=3;
  - UART_CFG/DIV_RATIO default constants used to build RST_VALUES.
- No sub-module required. Storage, request decode and error logic fit in one module.

Test Plan:
- Reset with defaults -> Export = {8'h20,8'h81,8'h00,8'h00} (word3..word0); RdData=0; all pulses 0.
- Write Address=1, WrData=8'hA5 -> WrAck pulse next cycle, Export[15:8]=8'hA5 that cycle; read Address=1 next -> RdData=8'hA5 with RdData_Valid one cycle later.
- RO_MASK bit3=1, write Address=3 WrData=8'h04 -> Err pulse, ErrSticky=1, word3 stays 8'h20; ErrClr=1 -> ErrSticky=0.
- DEPTH=12, read Address=13 -> RdData=0, RdData_Valid=1, Err=1; write Address=13 -> no word changes.
- WrEn=RdEn=1 at Address=0 with WrData=8'hFF -> Err=1, RdData_Valid=0, word0 unchanged.
- Reads back-to-back on Address 0,1,2,3 -> four consecutive RdData_Valid pulses with correct data; assert RST mid-stream -> all outputs return to reset values immediately.
